mips_control_fsm: RTL and testbench
===================================

MIPS_CONTROL_FSM -- requirements
Module: mips_control_fsm

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: maximum cycles the FSM waits for mem_ready in any memory state.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 instruction  input  32  current instruction-register contents; opcode [31:26], funct [5:0].
REQ-005 zero  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  memory has completed the current read or write this cycle.
REQ-007 ALUSrc  output  1  0 selects register read2; 1 selects the sign-extended instruction[15:0].
REQ-008 ALUcontrol  output  4  ALU operation code.
REQ-009 IRWrite, PCWrite, MemRead, MemWrite, RegWrite, MemtoReg, RegDst, Jump, branch_taken  output  1 each  datapath strobes.
REQ-010 instr_done  output  1  one-cycle pulse when an instruction retires.
REQ-011 illegal, timeout  output  1 each  sticky error flags.
REQ-012 instr_count  output  32  count of retired instructions.

Function
REQ-013 ALUcontrol encodings: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
REQ-014 States: FETCH, DECODE, MEMADDR, MEMRD, MEMWB, MEMWR, REXEC, RWB, IEXEC, IWB, BRANCH, JUMP; Moore outputs except where noted.
REQ-015 FETCH: MemRead=1. On mem_ready: IRWrite=1 and PCWrite=1 (both Mealy), then go to DECODE. Otherwise stay in FETCH.
REQ-016 DECODE (one cycle) dispatches on opcode:
- 000000 -> REXEC
- 100011 or 101011 -> MEMADDR
- 000100 -> BRANCH
- 000010 -> JUMP
- 001000, 001100, 001101, 001010 -> IEXEC
- any other opcode -> set illegal, go to FETCH, no retire.
REQ-017 REXEC: ALUSrc=0. ALUcontrol from funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 100111 NOR. Next state RWB. Unknown funct -> set illegal, go to FETCH, no retire.
REQ-018 RWB: hold the REXEC ALUSrc/ALUcontrol; RegWrite=1, RegDst=1, MemtoReg=0; retire; go to FETCH.
REQ-019 IEXEC: ALUSrc=1. ALUcontrol: addi ADD, andi AND, ori OR, slti SLT. Next state IWB.
REQ-020 IWB: hold the IEXEC controls; RegWrite=1, RegDst=0, MemtoReg=0; retire; go to FETCH.
REQ-021 MEMADDR: ALUSrc=1, ALUcontrol=ADD. Go to MEMRD for lw, MEMWR for sw.
REQ-022 MEMRD: MemRead=1, ALUSrc=1, ALUcontrol=ADD. On mem_ready go to MEMWB. MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; retire; go to FETCH.
REQ-023 MEMWR: MemWrite=1, ALUSrc=1, ALUcontrol=ADD. On mem_ready retire and go to FETCH.
REQ-024 BRANCH: ALUSrc=0, ALUcontrol=SUB, branch_taken=zero (Mealy); retire; go to FETCH.
REQ-025 JUMP: Jump=1, PCWrite=1; retire; go to FETCH.
REQ-026 In all states not listed above, every strobe is 0, ALUSrc=0 and ALUcontrol=0010.
REQ-027 Retire means instr_done=1 for that cycle and instr_count increments by 1 at the next edge; instr_count wraps modulo 2^32.
REQ-028 A wait counter clears on entry to FETCH, MEMRD and MEMWR, and increments each cycle mem_ready is low.
REQ-029 If the wait counter reaches MEM_TIMEOUT with mem_ready still low: set timeout, go to FETCH with no retire and no strobes that cycle.
REQ-030 If mem_ready and the timeout condition occur in the same cycle, mem_ready wins.
REQ-031 illegal and timeout clear only on reset.

Reset
REQ-032 When reset is high at a clock edge:
- state -> FETCH
- instr_count, wait counter, illegal and timeout -> 0
- all strobes, instr_done and branch_taken -> 0
- ALUSrc=0, ALUcontrol=0010.
REQ-033 Reset asserted in any state, including mid-memory-wait, aborts the instruction with no retire; the first cycle after reset is FETCH.

Structure
REQ-034 A shared package holds the state enumeration, the opcode and funct constants, and the ALUcontrol encodings (also used by the ALU datapath).
REQ-035 One sub-module, alu_func_decode, maps {state, opcode, funct} to {ALUSrc, ALUcontrol, funct_illegal}; it is purely combinational.

Verification
REQ-036 add: 0x012A4020 with mem_ready=1 -> FETCH, DECODE, REXEC, RWB. RWB shows ALUcontrol 0010, RegWrite=1, RegDst=1; instr_count 0->1.
REQ-037 lw: 0x8D280004 with mem_ready held low for 3 cycles in MEMRD -> MEMRD lasts 4 cycles; MEMWB shows MemtoReg=1, RegWrite=1; one instr_done pulse.
REQ-038 beq: 0x11090003 with zero=1 -> branch_taken=1 in BRANCH. The same instruction with zero=0 -> branch_taken=0; both retire.
REQ-039 Illegal: opcode 0x3F, and separately opcode 0 with funct 0x3F -> illegal=1, instr_count unchanged, next state FETCH.
REQ-040 Timeout: MEM_TIMEOUT=4, sw with mem_ready never high -> timeout=1 after 4 wait cycles, return to FETCH, MemWrite deasserted.
REQ-041 Reset mid-MEMWR wait -> next cycle is FETCH, all outputs at their reset values, instr_count=0.

Source files
------------

// File: rtl/mips_control_fsm_pkg.sv
// Shared types and encodings for the multicycle MIPS control path.
// The ALU encodings are also consumed by the ALU datapath.
package mips_control_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADDR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_REXEC,
    S_RWB,
    S_IEXEC,
    S_IWB,
    S_BRANCH,
    S_JUMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // States in which the FSM may stall on mem_ready.
  function automatic logic is_mem_wait(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mips_control_fsm_alu_decode.sv
// Combinational ALU operand/operation select from state, opcode and funct.
module alu_func_decode
  import mips_control_fsm_pkg::*;
(
  input  state_t     state_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic       alu_src_o,
  output logic [3:0] alu_ctrl_o,
  output logic       funct_illegal_o
);

  logic [3:0] fn_ctrl;
  logic [3:0] imm_ctrl;

  always_comb begin
    fn_ctrl         = ALU_ADD;
    funct_illegal_o = 1'b0;
    case (funct_i)
      FN_ADD:  fn_ctrl = ALU_ADD;
      FN_SUB:  fn_ctrl = ALU_SUB;
      FN_AND:  fn_ctrl = ALU_AND;
      FN_OR:   fn_ctrl = ALU_OR;
      FN_SLT:  fn_ctrl = ALU_SLT;
      FN_NOR:  fn_ctrl = ALU_NOR;
      default: funct_illegal_o = 1'b1;
    endcase
  end

  always_comb begin
    imm_ctrl = ALU_ADD;
    case (opcode_i)
      OP_ANDI: imm_ctrl = ALU_AND;
      OP_ORI:  imm_ctrl = ALU_OR;
      OP_SLTI: imm_ctrl = ALU_SLT;
      default: imm_ctrl = ALU_ADD;
    endcase
  end

  // Writeback states repeat their execute-state selection so the ALU result stays stable.
  always_comb begin
    alu_src_o  = 1'b0;
    alu_ctrl_o = ALU_ADD;
    case (state_i)
      S_REXEC, S_RWB: alu_ctrl_o = fn_ctrl;
      S_IEXEC, S_IWB: begin
        alu_src_o  = 1'b1;
        alu_ctrl_o = imm_ctrl;
      end
      S_MEMADDR, S_MEMRD, S_MEMWR: alu_src_o = 1'b1;
      S_BRANCH: alu_ctrl_o = ALU_SUB;
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_control_fsm.sv
// Multicycle MIPS control FSM with memory-wait timeout, sticky error flags
// and a retired-instruction counter.
module mips_control_fsm
  import mips_control_fsm_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        ALUSrc,
  output logic [3:0]  ALUcontrol,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        MemtoReg,
  output logic        RegDst,
  output logic        Jump,
  output logic        branch_taken,
  output logic        instr_done,
  output logic        illegal,
  output logic        timeout,
  output logic [31:0] instr_count
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);

  state_t            state_q, state_d;
  logic [WCW-1:0]    wait_q, wait_d;
  logic [31:0]       count_q, count_d;
  logic              illegal_q, illegal_d;
  logic              timeout_q, timeout_d;
  logic              retire, tmo_evt;
  logic              alu_src, funct_illegal;
  logic [3:0]        alu_ctrl;
  logic [5:0]        opcode, funct;
  logic              unused_instr_bits;

  assign opcode            = instruction[31:26];
  assign funct             = instruction[5:0];
  assign unused_instr_bits = ^instruction[25:6];

  alu_func_decode u_alu_dec (
    .state_i         (state_q),
    .opcode_i        (opcode),
    .funct_i         (funct),
    .alu_src_o       (alu_src),
    .alu_ctrl_o      (alu_ctrl),
    .funct_illegal_o (funct_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    illegal_d    = illegal_q;
    timeout_d    = timeout_q;
    retire       = 1'b0;
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    RegWrite     = 1'b0;
    MemtoReg     = 1'b0;
    RegDst       = 1'b0;
    Jump         = 1'b0;
    branch_taken = 1'b0;
    // mem_ready is excluded here, so a completing access always beats the timeout.
    tmo_evt = is_mem_wait(state_q) && !mem_ready && (wait_q == WCW'(MEM_TIMEOUT));

    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          MemRead = 1'b1;
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end else if (tmo_evt) begin
          timeout_d = 1'b1;
        end else begin
          MemRead = 1'b1;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:                           state_d = S_REXEC;
          OP_LW, OP_SW:                       state_d = S_MEMADDR;
          OP_BEQ:                             state_d = S_BRANCH;
          OP_J:                               state_d = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  state_d = S_IEXEC;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADDR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (mem_ready) begin
          MemRead = 1'b1;
          state_d = S_MEMWB;
        end else if (tmo_evt) begin
          timeout_d = 1'b1;
          state_d   = S_FETCH;
        end else begin
          MemRead = 1'b1;
        end
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        if (mem_ready) begin
          MemWrite = 1'b1;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else if (tmo_evt) begin
          timeout_d = 1'b1;
          state_d   = S_FETCH;
        end else begin
          MemWrite = 1'b1;
        end
      end
      S_REXEC: begin
        if (funct_illegal) begin
          illegal_d = 1'b1;
          state_d   = S_FETCH;
        end else begin
          state_d = S_RWB;
        end
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_IEXEC: state_d = S_IWB;
      S_IWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        branch_taken = zero;
        retire       = 1'b1;
        state_d      = S_FETCH;
      end
      S_JUMP: begin
        Jump    = 1'b1;
        PCWrite = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    if ((state_d != state_q) || tmo_evt) begin
      wait_d = '0;
    end else if (is_mem_wait(state_q) && !mem_ready) begin
      wait_d = wait_q + WCW'(1);
    end else begin
      wait_d = wait_q;
    end

    count_d    = count_q + {31'd0, retire};
    instr_done = retire;
    ALUSrc     = alu_src;
    ALUcontrol = alu_ctrl;

    // Outputs show their idle values for as long as reset is held.
    if (reset) begin
      IRWrite      = 1'b0;
      PCWrite      = 1'b0;
      MemRead      = 1'b0;
      MemWrite     = 1'b0;
      RegWrite     = 1'b0;
      MemtoReg     = 1'b0;
      RegDst       = 1'b0;
      Jump         = 1'b0;
      branch_taken = 1'b0;
      instr_done   = 1'b0;
      ALUSrc       = 1'b0;
      ALUcontrol   = ALU_ADD;
    end
  end

  assign illegal     = illegal_q;
  assign timeout     = timeout_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_mips_control_fsm.sv
// Scoreboard bench for mips_control_fsm: per-cycle expected outputs are queued
// with their mem_ready/zero stimulus and compared as the DUT steps through them.
module tb_mips_control_fsm;

  localparam logic [3:0] A_AND = 4'b0000;
  localparam logic [3:0] A_OR  = 4'b0001;
  localparam logic [3:0] A_ADD = 4'b0010;
  localparam logic [3:0] A_SUB = 4'b0110;
  localparam logic [3:0] A_SLT = 4'b0111;
  localparam logic [3:0] A_NOR = 4'b1100;

  // strobe bits: IRWrite PCWrite MemRead MemWrite RegWrite MemtoReg RegDst Jump branch_taken instr_done
  localparam logic [9:0] IRW = 10'b1000000000;
  localparam logic [9:0] PCW = 10'b0100000000;
  localparam logic [9:0] MRD = 10'b0010000000;
  localparam logic [9:0] MWR = 10'b0001000000;
  localparam logic [9:0] RGW = 10'b0000100000;
  localparam logic [9:0] M2R = 10'b0000010000;
  localparam logic [9:0] RDS = 10'b0000001000;
  localparam logic [9:0] JMP = 10'b0000000100;
  localparam logic [9:0] BRT = 10'b0000000010;
  localparam logic [9:0] DON = 10'b0000000001;
  localparam logic [9:0] NON = 10'b0000000000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        zero;
  logic        mem_ready;
  logic        ALUSrc;
  logic [3:0]  ALUcontrol;
  logic        IRWrite, PCWrite, MemRead, MemWrite, RegWrite, MemtoReg, RegDst, Jump;
  logic        branch_taken, instr_done, illegal, timeout;
  logic [31:0] instr_count;
  logic [14:0] obs;

  typedef struct {
    logic        mr;
    logic        z;
    logic [14:0] exp;
    string       tag;
  } sb_t;

  sb_t         sb[$];
  int          checks = 0;
  int          fails  = 0;
  logic [31:0] exp_count = 0;

  always #5 clk = ~clk;

  mips_control_fsm #(.MEM_TIMEOUT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .instruction  (instruction),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .ALUSrc       (ALUSrc),
    .ALUcontrol   (ALUcontrol),
    .IRWrite      (IRWrite),
    .PCWrite      (PCWrite),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .RegWrite     (RegWrite),
    .MemtoReg     (MemtoReg),
    .RegDst       (RegDst),
    .Jump         (Jump),
    .branch_taken (branch_taken),
    .instr_done   (instr_done),
    .illegal      (illegal),
    .timeout      (timeout),
    .instr_count  (instr_count)
  );

  assign obs = {ALUSrc, ALUcontrol, IRWrite, PCWrite, MemRead, MemWrite,
                RegWrite, MemtoReg, RegDst, Jump, branch_taken, instr_done};

  function automatic logic [14:0] v(input logic src, input logic [3:0] ac, input logic [9:0] st);
    return {src, ac, st};
  endfunction

  task automatic push(input logic mr, input logic z, input logic [14:0] e, input string tag);
    sb_t s;
    s.mr = mr; s.z = z; s.exp = e; s.tag = tag;
    sb.push_back(s);
  endtask

  task automatic push_fetch();
    push(1'b1, 1'b0, v(1'b0, A_ADD, IRW | PCW | MRD), "fetch");
  endtask

  // Drain the scoreboard one cycle per entry; bounded by the queue length.
  task automatic run_sb();
    sb_t s;
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(negedge clk);
      mem_ready = s.mr;
      zero      = s.z;
      #1;
      checks++;
      if (obs !== s.exp) begin
        fails++;
        $display("FAIL %s: outputs got %b expected %b", s.tag, obs, s.exp);
      end
      if (s.exp[0]) exp_count++;
    end
  endtask

  task automatic check_count(input string tag);
    @(posedge clk);
    #1;
    checks++;
    if (instr_count !== exp_count) begin
      fails++;
      $display("FAIL %s count: got %0d expected %0d", tag, instr_count, exp_count);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset     = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    reset     = 1'b0;
    exp_count = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (obs !== v(1'b0, A_ADD, NON)) begin
      fails++; $display("FAIL reset outputs: got %b expected %b", obs, v(1'b0, A_ADD, NON));
    end
    checks++;
    if ({illegal, timeout} !== 2'b00 || instr_count !== 32'd0) begin
      fails++; $display("FAIL reset flags: got %b/%0d expected 00/0", {illegal, timeout}, instr_count);
    end
    reset = 1'b0;
  endtask

  task automatic test_rtype(input logic [31:0] ins, input logic [3:0] ac, input string tag);
    instruction = ins;
    push_fetch();
    push(1'b1, 1'b0, v(1'b0, A_ADD, NON), {tag, " decode"});
    push(1'b1, 1'b0, v(1'b0, ac, NON), {tag, " rexec"});
    push(1'b1, 1'b0, v(1'b0, ac, RGW | RDS | DON), {tag, " rwb"});
    run_sb();
    check_count(tag);
  endtask

  task automatic test_itype(input logic [31:0] ins, input logic [3:0] ac, input string tag);
    instruction = ins;
    push_fetch();
    push(1'b1, 1'b0, v(1'b0, A_ADD, NON), {tag, " decode"});
    push(1'b1, 1'b0, v(1'b1, ac, NON), {tag, " iexec"});
    push(1'b1, 1'b0, v(1'b1, ac, RGW | DON), {tag, " iwb"});
    run_sb();
    check_count(tag);
  endtask

  task automatic test_lw(input int waits, input string tag);
    instruction = 32'h8D28_0004;
    push_fetch();
    push(1'b1, 1'b0, v(1'b0, A_ADD, NON), {tag, " decode"});
    push(1'b1, 1'b0, v(1'b1, A_ADD, NON), {tag, " memaddr"});
    for (int i = 0; i < waits; i++) push(1'b0, 1'b0, v(1'b1, A_ADD, MRD), {tag, " memrd wait"});
    push(1'b1, 1'b0, v(1'b1, A_ADD, MRD), {tag, " memrd ready"});
    push(1'b1, 1'b0, v(1'b0, A_ADD, RGW | M2R | DON), {tag, " memwb"});
    run_sb();
    check_count(tag);
  endtask

  task automatic test_sw();
    instruction = 32'hAD28_0004;
    push_fetch();
    push(1'b1, 1'b0, v(1'b0, A_ADD, NON), "sw decode");
    push(1'b1, 1'b0, v(1'b1, A_ADD, NON), "sw memaddr");
    push(1'b0, 1'b0, v(1'b1, A_ADD, MWR), "sw memwr wait");
    push(1'b1, 1'b0, v(1'b1, A_ADD, MWR | DON), "sw memwr ready");
    run_sb();
    check_count("sw");
  endtask

  task automatic test_branch(input logic z, input string tag);
    instruction = 32'h1109_0003;
    push_fetch();
    push(1'b1, z, v(1'b0, A_ADD, NON), {tag, " decode"});
    push(1'b1, z, v(1'b0, A_SUB, (z ? BRT : NON) | DON), {tag, " branch"});
    run_sb();
    check_count(tag);
  endtask

  task automatic test_jump();
    instruction = 32'h0800_0010;
    push_fetch();
    push(1'b1, 1'b0, v(1'b0, A_ADD, NON), "j decode");
    push(1'b1, 1'b0, v(1'b0, A_ADD, JMP | PCW | DON), "j jump");
    run_sb();
    check_count("j");
  endtask

  task automatic test_ready_wins();
    test_lw(4, "lw ready at limit");
    checks++;
    if (timeout !== 1'b0 || illegal !== 1'b0) begin
      fails++; $display("FAIL ready_wins flags: got %b%b expected 00", illegal, timeout);
    end
  endtask

  task automatic test_illegal_opcode();
    instruction = 32'hFC00_0000;
    push_fetch();
    push(1'b1, 1'b0, v(1'b0, A_ADD, NON), "bad op decode");
    push(1'b0, 1'b0, v(1'b0, A_ADD, MRD), "bad op back to fetch");
    run_sb();
    checks++;
    if (illegal !== 1'b1) begin
      fails++; $display("FAIL illegal_opcode flag: got %b expected 1", illegal);
    end
    check_count("illegal opcode");
  endtask

  task automatic test_reset_mid_memwr();
    instruction = 32'hAD28_0004;
    push_fetch();
    push(1'b1, 1'b0, v(1'b0, A_ADD, NON), "rst sw decode");
    push(1'b1, 1'b0, v(1'b1, A_ADD, NON), "rst sw memaddr");
    push(1'b0, 1'b0, v(1'b1, A_ADD, MWR), "rst sw wait0");
    push(1'b0, 1'b0, v(1'b1, A_ADD, MWR), "rst sw wait1");
    run_sb();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== v(1'b0, A_ADD, NON)) begin
      fails++; $display("FAIL reset_mid outputs: got %b expected %b", obs, v(1'b0, A_ADD, NON));
    end
    @(negedge clk);
    #1;
    checks++;
    if (obs !== v(1'b0, A_ADD, NON) || instr_count !== 32'd0 || {illegal, timeout} !== 2'b00) begin
      fails++; $display("FAIL reset_mid state: got %b/%0d/%b%b expected %b/0/00",
                        obs, instr_count, illegal, timeout, v(1'b0, A_ADD, NON));
    end
    reset     = 1'b0;
    mem_ready = 1'b0;
    exp_count = 0;
    push_fetch();
    push(1'b1, 1'b0, v(1'b0, A_ADD, NON), "post rst decode");
    push(1'b1, 1'b0, v(1'b1, A_ADD, NON), "post rst memaddr");
    push(1'b1, 1'b0, v(1'b1, A_ADD, MWR | DON), "post rst memwr");
    run_sb();
    check_count("post reset sw");
  endtask

  task automatic test_illegal_funct();
    apply_reset();
    instruction = 32'h012A_403F;
    push_fetch();
    push(1'b1, 1'b0, v(1'b0, A_ADD, NON), "bad fn decode");
    push(1'b1, 1'b0, v(1'b0, A_ADD, NON), "bad fn rexec");
    push(1'b0, 1'b0, v(1'b0, A_ADD, MRD), "bad fn back to fetch");
    run_sb();
    checks++;
    if (illegal !== 1'b1) begin
      fails++; $display("FAIL illegal_funct flag: got %b expected 1", illegal);
    end
    check_count("illegal funct");
  endtask

  task automatic test_timeout();
    apply_reset();
    instruction = 32'hAD28_0004;
    push_fetch();
    push(1'b1, 1'b0, v(1'b0, A_ADD, NON), "tmo decode");
    push(1'b1, 1'b0, v(1'b1, A_ADD, NON), "tmo memaddr");
    for (int i = 0; i < 4; i++) push(1'b0, 1'b0, v(1'b1, A_ADD, MWR), "tmo memwr wait");
    push(1'b0, 1'b0, v(1'b1, A_ADD, NON), "tmo expiry cycle");
    push(1'b0, 1'b0, v(1'b0, A_ADD, MRD), "tmo back to fetch");
    run_sb();
    checks++;
    if (timeout !== 1'b1 || illegal !== 1'b0) begin
      fails++; $display("FAIL timeout flags: got illegal=%b timeout=%b expected 0/1", illegal, timeout);
    end
    check_count("timeout");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    instruction = 32'h0;
    zero        = 1'b0;
    mem_ready   = 1'b0;
    test_reset();
    test_rtype(32'h012A_4020, A_ADD, "add");
    test_rtype(32'h012A_4022, A_SUB, "sub");
    test_rtype(32'h012A_4027, A_NOR, "nor");
    test_rtype(32'h012A_402A, A_SLT, "slt");
    test_lw(3, "lw");
    test_sw();
    test_branch(1'b1, "beq taken");
    test_branch(1'b0, "beq not taken");
    test_jump();
    test_itype(32'h3509_00FF, A_OR,  "ori");
    test_itype(32'h2909_0001, A_SLT, "slti");
    test_itype(32'h3109_0001, A_AND, "andi");
    test_itype(32'h2109_0001, A_ADD, "addi");
    test_ready_wins();
    test_illegal_opcode();
    test_reset_mid_memwr();
    test_illegal_funct();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
